// File: rtl/mem_arb_pkg.sv
// ============================================================
// mem_arb_pkg: shared types and round-robin search for the multi-core memory
// Rev 1.0
// ============================================================
`default_nettype none

package mem_arb_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // First requester at or above ptr, wrapping modulo n; returns 0 when nothing requests.
  function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                n);
    logic [2:0] pick;
    logic       found;
    logic [2:0] c3;
    int         c;
    pick  = 3'd0;
    found = 1'b0;
    for (int k = 0; k < MAX_CH; k++) begin
      c  = (int'(ptr) + k) % n;
      c3 = 3'(c);
      if (k < n && !found && req[c3]) begin
        pick  = c3;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================
// rr_arbiter: combinational round-robin grant starting from ptr
// Rev 1.0
// ============================================================
`default_nettype none

module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [2:0]        ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [2:0]        idx,
  output logic              any
);

  logic [MAX_CH-1:0] req_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_CH-1:0]  = req;
    any                  = |req;
    idx                  = rr_pick(req_ext, ptr, NUM_CH);
    gnt                  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt[i] = any && (idx == 3'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_core_mem_arbiter.sv
// ============================================================
// multi_core_mem_arbiter: round-robin shared word memory for NUM_CH picorv32 cores
// Rev 1.0
// ============================================================
`default_nettype none

module multi_core_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          DEPTH_WORDS = 16384,
  parameter int          LATENCY     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_CH-1:0]    mem_valid,
  input  logic [NUM_CH-1:0]    mem_instr,
  input  logic [NUM_CH*32-1:0] mem_addr,
  input  logic [NUM_CH*32-1:0] mem_wdata,
  input  logic [NUM_CH*4-1:0]  mem_wstrb,
  output logic [NUM_CH-1:0]    mem_ready,
  output logic [NUM_CH*32-1:0] mem_rdata,
  output logic                 err_valid,
  output logic [2:0]           err_ch,
  output logic [31:0]          err_addr,
  output logic [31:0]          fetch_count
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  logic [31:0] mem [DEPTH_WORDS];

  state_e      state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  gnt_ch_q, gnt_ch_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        instr_q, instr_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_hit_q, err_hit_d;
  logic        err_sticky_q, err_sticky_d;
  logic [2:0]  err_ch_q, err_ch_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [NUM_CH-1:0] arb_gnt;
  logic [2:0]        arb_idx;
  logic              arb_any;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req (mem_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_instr;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_instr = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_gnt[i]) begin
        sel_addr  = mem_addr[32*i +: 32];
        sel_wdata = mem_wdata[32*i +: 32];
        sel_wstrb = mem_wstrb[4*i +: 4];
        sel_instr = mem_instr[i];
      end
    end
  end

  // With LATENCY=0 the commit edge is also the accept edge, so use the live selection in IDLE.
  logic        in_idle;
  logic [2:0]  cur_ch;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;
  logic        cur_instr;

  assign in_idle   = (state_q == IDLE);
  assign cur_ch    = in_idle ? arb_idx   : gnt_ch_q;
  assign cur_addr  = in_idle ? sel_addr  : addr_q;
  assign cur_wdata = in_idle ? sel_wdata : wdata_q;
  assign cur_wstrb = in_idle ? sel_wstrb : wstrb_q;
  assign cur_instr = in_idle ? sel_instr : instr_q;

  logic          off_borrow;
  logic [31:0]   off;
  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          commit;
  logic          unused_off_lsbs;

  assign {off_borrow, off} = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
  assign word_idx          = off[AW+1:2];
  assign in_range          = !off_borrow && (off[31:AW+2] == '0);
  assign commit            = (state_d == RESP);
  assign unused_off_lsbs   = &{1'b0, off[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      gnt_ch_q      <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      instr_q       <= 1'b0;
      wait_cnt_q    <= '0;
      rdata_q       <= '0;
      err_hit_q     <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_ch_q      <= '0;
      err_addr_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_ch_q      <= gnt_ch_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      instr_q       <= instr_d;
      wait_cnt_q    <= wait_cnt_d;
      rdata_q       <= rdata_d;
      err_hit_q     <= err_hit_d;
      err_sticky_q  <= err_sticky_d;
      err_ch_q      <= err_ch_d;
      err_addr_q    <= err_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any) state_d = (LATENCY > 0) ? WAIT : RESP;
      WAIT:    if (wait_cnt_q <= 4'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    gnt_ch_d      = gnt_ch_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    instr_d       = instr_q;
    wait_cnt_d    = wait_cnt_q;
    rdata_d       = rdata_q;
    err_hit_d     = err_hit_q;
    err_sticky_d  = err_sticky_q;
    err_ch_d      = err_ch_q;
    err_addr_d    = err_addr_q;
    fetch_count_d = fetch_count_q;

    if (in_idle && arb_any) begin
      gnt_ch_d   = arb_idx;
      addr_d     = sel_addr;
      wdata_d    = sel_wdata;
      wstrb_d    = sel_wstrb;
      instr_d    = sel_instr;
      wait_cnt_d = LAT_CNT;
    end
    if (state_q == WAIT) wait_cnt_d = wait_cnt_q - 4'd1;
    if (state_q == RESP) rr_ptr_d = (gnt_ch_q == 3'(NUM_CH-1)) ? 3'd0 : gnt_ch_q + 3'd1;

    if (commit) begin
      rdata_d   = (in_range && cur_wstrb == 4'd0) ? mem[word_idx] : 32'd0;
      err_hit_d = !in_range;
      if (!in_range && !err_sticky_q) begin
        err_sticky_d = 1'b1;
        err_ch_d     = cur_ch;
        err_addr_d   = cur_addr;
      end
      if (cur_instr && fetch_count_q != 32'hFFFF_FFFF) fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_wstrb[b]) mem[word_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    mem_ready = '0;
    mem_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q == RESP && gnt_ch_q == 3'(i)) begin
        mem_ready[i]          = 1'b1;
        mem_rdata[32*i +: 32] = rdata_q;
      end
    end
    err_valid   = (state_q == RESP) && err_hit_q;
    err_ch      = err_ch_q;
    err_addr    = err_addr_q;
    fetch_count = fetch_count_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_core_mem_arbiter.sv
// ============================================================
// tb_multi_core_mem_arbiter: directed vectors over three arbiter configurations
// Rev 1.0
// ============================================================
`default_nettype none

module tb_multi_core_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: 3 channels, no wait states. B: 2 channels, LATENCY=3. C: 2 channels, LATENCY=5.
  logic        a_resetn, b_resetn, c_resetn;
  logic [2:0]  a_valid, a_instr, a_ready;
  logic [95:0] a_addr, a_wdata, a_rdata;
  logic [11:0] a_wstrb;
  logic        a_err_valid;
  logic [2:0]  a_err_ch;
  logic [31:0] a_err_addr, a_fetch;

  logic [1:0]  b_valid, b_instr, b_ready;
  logic [63:0] b_addr, b_wdata, b_rdata;
  logic [7:0]  b_wstrb;
  logic        b_err_valid;
  logic [2:0]  b_err_ch;
  logic [31:0] b_err_addr, b_fetch;

  logic [1:0]  c_valid, c_instr, c_ready;
  logic [63:0] c_addr, c_wdata, c_rdata;
  logic [7:0]  c_wstrb;
  logic        c_err_valid;
  logic [2:0]  c_err_ch;
  logic [31:0] c_err_addr, c_fetch;

  multi_core_mem_arbiter #(.NUM_CH(3), .DEPTH_WORDS(16384), .LATENCY(0)) u_a (
    .clk(clk), .resetn(a_resetn), .mem_valid(a_valid), .mem_instr(a_instr),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_wstrb(a_wstrb), .mem_ready(a_ready),
    .mem_rdata(a_rdata), .err_valid(a_err_valid), .err_ch(a_err_ch),
    .err_addr(a_err_addr), .fetch_count(a_fetch)
  );

  multi_core_mem_arbiter #(.NUM_CH(2), .DEPTH_WORDS(16384), .LATENCY(3)) u_b (
    .clk(clk), .resetn(b_resetn), .mem_valid(b_valid), .mem_instr(b_instr),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wstrb(b_wstrb), .mem_ready(b_ready),
    .mem_rdata(b_rdata), .err_valid(b_err_valid), .err_ch(b_err_ch),
    .err_addr(b_err_addr), .fetch_count(b_fetch)
  );

  multi_core_mem_arbiter #(.NUM_CH(2), .DEPTH_WORDS(16384), .LATENCY(5)) u_c (
    .clk(clk), .resetn(c_resetn), .mem_valid(c_valid), .mem_instr(c_instr),
    .mem_addr(c_addr), .mem_wdata(c_wdata), .mem_wstrb(c_wstrb), .mem_ready(c_ready),
    .mem_rdata(c_rdata), .err_valid(c_err_valid), .err_ch(c_err_ch),
    .err_addr(c_err_addr), .fetch_count(c_fetch)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input int ch, input logic v, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, input logic instr);
    case (d)
      0: begin
        a_valid[ch] = v; a_instr[ch] = instr; a_addr[32*ch +: 32] = addr;
        a_wdata[32*ch +: 32] = wdata; a_wstrb[4*ch +: 4] = strb;
      end
      1: begin
        b_valid[ch] = v; b_instr[ch] = instr; b_addr[32*ch +: 32] = addr;
        b_wdata[32*ch +: 32] = wdata; b_wstrb[4*ch +: 4] = strb;
      end
      default: begin
        c_valid[ch] = v; c_instr[ch] = instr; c_addr[32*ch +: 32] = addr;
        c_wdata[32*ch +: 32] = wdata; c_wstrb[4*ch +: 4] = strb;
      end
    endcase
  endtask

  function automatic logic [7:0] get_ready(input int d);
    case (d)
      0:       return {5'd0, a_ready};
      1:       return {6'd0, b_ready};
      default: return {6'd0, c_ready};
    endcase
  endfunction

  function automatic logic [95:0] get_rbus(input int d);
    case (d)
      0:       return a_rdata;
      1:       return {32'd0, b_rdata};
      default: return {32'd0, c_rdata};
    endcase
  endfunction

  function automatic logic get_err(input int d);
    case (d)
      0:       return a_err_valid;
      1:       return b_err_valid;
      default: return c_err_valid;
    endcase
  endfunction

  // Core-like access: hold valid until ready, drop it, then spend the return-to-IDLE cycle.
  task automatic xact(input int d, input int ch, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic instr, output logic [7:0] rdy,
                      output logic [95:0] rbus, output logic ev, output int cyc);
    drive(d, ch, 1'b1, addr, wdata, strb, instr);
    rdy = '0; rbus = '0; ev = 1'b0; cyc = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (get_ready(d) != 8'd0) begin
        rdy  = get_ready(d);
        rbus = get_rbus(d);
        ev   = get_err(d);
        cyc  = k;
        break;
      end
    end
    drive(d, ch, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
    tick();
  endtask

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rdy, seen;
    logic [95:0] rbus, exp_bus;
    logic        ev;
    int          cyc;

    vecs[0] = '{0, 32'h0000_0010, 32'h0,         4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1, 32'h0000_0014, 32'hAABB_CCDD, 4'b1111, 1'b0, 32'h0,         1'b0};
    vecs[2] = '{2, 32'h0000_0014, 32'h0,         4'b0000, 1'b0, 32'hAABB_CCDD, 1'b0};
    vecs[3] = '{0, 32'h0000_0018, 32'hFFFF_FFFF, 4'b1000, 1'b0, 32'h0,         1'b0};
    vecs[4] = '{1, 32'h0000_001B, 32'h0,         4'b0000, 1'b0, 32'hFF34_5678, 1'b0};
    vecs[5] = '{2, 32'h0001_0000, 32'h0,         4'b0000, 1'b0, 32'h0,         1'b1};
    vecs[6] = '{0, 32'h0002_0000, 32'h1234_5678, 4'b1111, 1'b0, 32'h0,         1'b1};
    vecs[7] = '{1, 32'h0000_FFFC, 32'h0,         4'b0000, 1'b0, 32'hCAFE_F00D, 1'b0};

    a_resetn = 1'b0; b_resetn = 1'b0; c_resetn = 1'b0;
    a_valid = '0; a_instr = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
    b_valid = '0; b_instr = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
    c_valid = '0; c_instr = '0; c_addr = '0; c_wdata = '0; c_wstrb = '0;

    u_a.mem[4]     = 32'hDEAD_BEEF;
    u_a.mem[5]     = 32'h0;
    u_a.mem[6]     = 32'h1234_5678;
    u_a.mem[16383] = 32'hCAFE_F00D;
    u_b.mem[8]     = 32'h0;
    u_c.mem[8]     = 32'h55AA_55AA;

    repeat (3) tick();
    check("rst_ready",   96'(a_ready), 96'd0);
    check("rst_rdata",   a_rdata, 96'd0);
    check("rst_err_v",   96'(a_err_valid), 96'd0);
    check("rst_err_ch",  96'(a_err_ch), 96'd0);
    check("rst_err_adr", 96'(a_err_addr), 96'd0);
    check("rst_fetch",   96'(a_fetch), 96'd0);
    a_resetn = 1'b1; b_resetn = 1'b1; c_resetn = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      xact(0, vecs[i].ch, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].instr,
           rdy, rbus, ev, cyc);
      exp_bus = {64'd0, vecs[i].exp_rd} << (32 * vecs[i].ch);
      check($sformatf("v%0d_ready", i), 96'(rdy), 96'(8'd1 << vecs[i].ch));
      check($sformatf("v%0d_rdata", i), rbus, exp_bus);
      check($sformatf("v%0d_err", i), 96'(ev), 96'(vecs[i].exp_err));
      check($sformatf("v%0d_lat", i), 96'(cyc), 96'd1);
    end
    check("sticky_ch",    96'(a_err_ch), 96'd2);
    check("sticky_addr",  96'(a_err_addr), 96'h0001_0000);
    check("fetch_table",  96'(a_fetch), 96'd1);
    check("err_v_idle",   96'(a_err_valid), 96'd0);

    // Continuous requests on all channels after a fresh reset.
    a_resetn = 1'b0;
    tick();
    check("rst2_err_ch",  96'(a_err_ch), 96'd0);
    check("rst2_err_adr", 96'(a_err_addr), 96'd0);
    check("rst2_fetch",   96'(a_fetch), 96'd0);
    a_resetn = 1'b1;
    tick();
    for (int ch = 0; ch < 3; ch++) drive(0, ch, 1'b1, 32'h10, 32'h0, 4'd0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("rr_cycle%0d", k), 96'(a_ready),
            (k % 2 == 1) ? 96'(3'd1 << (((k - 1) / 2) % 3)) : 96'd0);
    end
    for (int ch = 0; ch < 3; ch++) drive(0, ch, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0);
    repeat (2) tick();

    for (int i = 0; i < 15; i++) begin
      xact(0, i % 3, 32'h10, 32'h0, 4'd0, (i < 10), rdy, rbus, ev, cyc);
    end
    check("fetch_count", 96'(a_fetch), 96'd10);

    xact(1, 1, 32'h20, 32'h1122_3344, 4'b0101, 1'b0, rdy, rbus, ev, cyc);
    check("b_wr_ready", 96'(rdy), 96'h2);
    check("b_wr_lat",   96'(cyc), 96'd4);
    check("b_wr_rdata", rbus, 96'd0);
    check("b_mem8",     96'(u_b.mem[8]), 96'h0022_0044);
    xact(1, 0, 32'h20, 32'h0, 4'b0000, 1'b0, rdy, rbus, ev, cyc);
    check("b_rd_ready", 96'(rdy), 96'h1);
    check("b_rd_lat",   96'(cyc), 96'd4);
    check("b_rd_rdata", rbus, 96'h0022_0044);

    seen = '0;
    drive(2, 0, 1'b1, 32'h20, 32'h0, 4'hF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      seen = seen | get_ready(2);
    end
    c_resetn = 1'b0;
    #1;
    check("c_rst_ready", 96'(c_ready), 96'd0);
    check("c_rst_rdata", 96'(c_rdata), 96'd0);
    check("c_rst_err",   96'({c_err_valid, c_err_ch, c_err_addr}), 96'd0);
    check("c_rst_fetch", 96'(c_fetch), 96'd0);
    check("c_rst_state", 96'(u_c.state_q), 96'(IDLE));
    drive(2, 0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0);
    repeat (2) tick();
    c_resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen = seen | get_ready(2);
    end
    check("c_no_ready", 96'(seen), 96'd0);
    check("c_mem8",     96'(u_c.mem[8]), 96'h55AA_55AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
